// File: rtl/coef_ram_loader.sv
// Runtime-loadable coefficient RAM: a valid/ready stream fills N_ADDR words, with a registered read port.
// Optional running checksum output enabled by defining COEF_RAM_LOADER_CHECKSUM_EN.
module coef_ram_loader #(
   parameter int N_ADDR     = 256,
   parameter int DATA_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [DATA_WIDTH-1:0]       din,
   input  logic                        din_valid,
   output logic                        din_ready,
   output logic [$clog2(N_ADDR)-1:0]   wadd,
   output logic                        busy,
   output logic                        done,
   input  logic                        ren,
   input  logic [$clog2(N_ADDR)-1:0]   radd,
   output logic [DATA_WIDTH-1:0]       wout,
`ifdef COEF_RAM_LOADER_CHECKSUM_EN
   output logic [DATA_WIDTH-1:0]       csum,
`endif
   output logic                        rvalid
);

   localparam int AW = $clog2(N_ADDR);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N_ADDR - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [AW-1:0]         r_wadd;
   logic [AW-1:0]         w_wadd_nxt;
   logic                  r_din_ready;
   logic                  w_ready_nxt;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_rvalid;
   logic                  w_xfer;
   logic [DATA_WIDTH-1:0] r_wout;
   logic [DATA_WIDTH-1:0] r_mem [N_ADDR];

   // Next-state, next write address and transfer qualification
   always_comb begin
      w_next      = r_state;
      w_wadd_nxt  = r_wadd;
      // A start in the same cycle discards any presented word
      w_xfer      = (r_state == S_LOAD) && r_din_ready && din_valid && !start;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_next     = S_LOAD;
               w_wadd_nxt = {AW{1'b0}};
            end else begin
               w_next     = r_state;
            end
         end
         S_LOAD: begin
            if (start) begin
               w_wadd_nxt = {AW{1'b0}};
            end else if (w_xfer) begin
               if (r_wadd == LAST_ADDR) begin
                  w_next     = S_DONE;
                  w_wadd_nxt = {AW{1'b0}};
               end else begin
                  w_wadd_nxt = r_wadd + AW'(1);
               end
            end else begin
               w_wadd_nxt = r_wadd;
            end
         end
         default: begin
            w_next     = S_IDLE;
            w_wadd_nxt = {AW{1'b0}};
         end
      endcase
      // Ready stays low for one cycle after a load is launched from IDLE/DONE
      w_ready_nxt = (w_next == S_LOAD) && !(start && (r_state != S_LOAD));
   end

   // State, address, status decodes and read port registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_wadd      <= {AW{1'b0}};
         r_din_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rvalid    <= 1'b0;
         r_wout      <= {DATA_WIDTH{1'b0}};
      end else begin
         r_state     <= w_next;
         r_wadd      <= w_wadd_nxt;
         r_din_ready <= w_ready_nxt;
         r_busy      <= (w_next == S_LOAD);
         r_done      <= (w_next == S_DONE);
         r_rvalid    <= ren;
         if (ren) begin
            r_wout <= r_mem[radd];
         end
      end
   end

   // Memory array write; contents survive reset, and reads see pre-write data
   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_mem[r_wadd] <= din;
      end
   end

`ifdef COEF_RAM_LOADER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_csum;

   // Running modulo sum of accepted words; start clears and wins over an add
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_csum <= {DATA_WIDTH{1'b0}};
      end else if (start) begin
         r_csum <= {DATA_WIDTH{1'b0}};
      end else if (w_xfer) begin
         r_csum <= r_csum + din;
      end
   end

   assign csum = r_csum;
`endif

   assign din_ready = r_din_ready;
   assign wadd      = r_wadd;
   assign busy      = r_busy;
   assign done      = r_done;
   assign wout      = r_wout;
   assign rvalid    = r_rvalid;

endmodule

// File: tb/tb_coef_ram_loader.sv
// Randomized self-checking bench for coef_ram_loader against a behavioural table-load model.
module tb_coef_ram_loader;
   localparam int N  = 256;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst, start, din_valid, ren;
   logic [DW-1:0] din;
   logic [AW-1:0] radd;
   logic          din_ready, busy, done, rvalid;
   logic [AW-1:0] wadd;
   logic [DW-1:0] wout;
`ifdef COEF_RAM_LOADER_CHECKSUM_EN
   logic [DW-1:0] csum;
`endif

   always #5 clk = ~clk;

   coef_ram_loader #(.N_ADDR(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .wadd(wadd), .busy(busy), .done(done),
      .ren(ren), .radd(radd), .wout(wout),
`ifdef COEF_RAM_LOADER_CHECKSUM_EN
      .csum(csum),
`endif
      .rvalid(rvalid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase of the load, next slot, and a shadow table
   int            m_phase;       // 0 idle, 1 loading, 2 complete
   int            m_next;
   bit            m_ready, m_rvalid, m_wout_known, m_took;
   logic [DW-1:0] m_wout, m_csum;
   logic [DW-1:0] m_mem [N];
   bit            m_known [N];

   task automatic model_reset();
      m_phase = 0; m_next = 0; m_ready = 0; m_rvalid = 0;
      m_wout = '0; m_wout_known = 1; m_csum = '0;
   endtask

   task automatic model_step(input bit st, input bit dv, input logic [DW-1:0] d,
                             input bit re, input int ra);
      bit was_loading;
      was_loading = (m_phase == 1);
      m_took = was_loading && m_ready && dv && !st;
      if (re) begin
         m_wout_known = m_known[ra];
         m_wout       = m_mem[ra];
      end
      m_rvalid = re;
      if (m_took) begin
         m_mem[m_next]   = d;
         m_known[m_next] = 1;
         m_csum          = m_csum + d;
         m_next++;
      end
      if (st) begin
         m_ready = was_loading;
         m_phase = 1; m_next = 0; m_csum = '0;
      end else if (m_next == N) begin
         m_phase = 2; m_next = 0; m_ready = 0;
      end else begin
         m_ready = (m_phase == 1);
      end
   endtask

   task automatic compare_all();
      check_val("din_ready", din_ready, m_ready);
      check_val("busy", busy, m_phase == 1);
      check_val("done", done, m_phase == 2);
      check_val("wadd", wadd, m_next);
      check_val("rvalid", rvalid, m_rvalid);
      if (m_wout_known) check_val("wout", wout, m_wout);
`ifdef COEF_RAM_LOADER_CHECKSUM_EN
      check_val("csum", csum, m_csum);
`endif
   endtask

   task automatic cyc(input bit st, input bit dv, input logic [DW-1:0] d, input bit re, input int ra);
      start = st; din_valid = dv; din = d; ren = re; radd = AW'(ra);
      @(posedge clk);
      model_step(st, dv, d, re, ra);
      #1;
      compare_all();
   endtask

   // Push n_words transfers; seq puts value==address, gaps randomizes valid and reads
   task automatic feed(input int n_words, input bit seq, input bit gaps);
      int got, budget;
      got = 0; budget = 0;
      while (got < n_words && budget < 4000) begin
         cyc(1'b0, gaps ? 1'($urandom % 2) : 1'b1,
             seq ? DW'(m_next) : DW'($urandom),
             gaps ? 1'($urandom % 2) : 1'b0, $urandom_range(0, N - 1));
         if (m_took) got++;
         budget++;
      end
      if (got < n_words) begin
         n_checks++; n_errors++;
         $display("FAIL feed_timeout: got %0d words expected %0d", got, n_words);
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_known[i] = 0;
      rst = 1'b1; start = 1'b0; din_valid = 1'b0; din = '0; ren = 1'b0; radd = '0;
      model_reset();
      #3;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // Full sequential load, then reads
      cyc(1'b1, 1'b0, '0, 1'b0, 0);
      check_val("ready_low_after_start", din_ready, 1'b0);
      feed(N, 1'b1, 1'b0);
      check_val("done_after_full", done, 1'b1);
      check_val("busy_after_full", busy, 1'b0);
      cyc(1'b0, 1'b1, 16'h5555, 1'b1, 0);
      check_val("rd0", wout, 16'd0);
      cyc(1'b0, 1'b0, '0, 1'b1, 100);
      check_val("rd100", wout, 16'd100);
      cyc(1'b0, 1'b0, '0, 1'b1, 255);
      check_val("rd255", wout, 16'd255);
      cyc(1'b0, 1'b0, '0, 1'b0, 0);
      check_val("wout_hold", wout, 16'd255);

      // Randomized load with gaps and concurrent reads
      cyc(1'b1, 1'b1, '0, 1'b0, 0);
      feed(N, 1'b0, 1'b1);
      check_val("done_after_gaps", done, 1'b1);

      // Restart mid-load: the word presented with start is dropped
      cyc(1'b1, 1'b0, '0, 1'b0, 0);
      feed(10, 1'b0, 1'b0);
      check_val("wadd_before_restart", wadd, 10);
      cyc(1'b1, 1'b1, 16'hBEEF, 1'b0, 0);
      check_val("wadd_restart", wadd, 0);
      cyc(1'b0, 1'b1, 16'h1234, 1'b0, 0);
      cyc(1'b0, 1'b0, '0, 1'b1, 0);
      check_val("restart_addr0", wout, 16'h1234);
      cyc(1'b0, 1'b0, '0, 1'b1, 10);

      // Read-first collision at address 5
      feed(4, 1'b1, 1'b0);
      check_val("wadd_at5", wadd, 5);
      cyc(1'b0, 1'b1, 16'hAAAA, 1'b1, 5);
      cyc(1'b0, 1'b0, '0, 1'b1, 5);
      check_val("collision_reread", wout, 16'hAAAA);

      // Async reset mid-load at address 37
      feed(31, 1'b1, 1'b0);
      check_val("wadd_at37", wadd, 37);
      cyc(1'b0, 1'b0, '0, 1'b1, 3);
      #2 rst = 1'b1;
      #1;
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_ready", din_ready, 1'b0);
      check_val("rst_rvalid", rvalid, 1'b0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 37; a++) cyc(1'b0, 1'b0, '0, 1'b1, a);
      cyc(1'b0, 1'b1, '0, 1'b0, 0);
      check_val("done_after_rst", done, 1'b0);

`ifdef COEF_RAM_LOADER_CHECKSUM_EN
      cyc(1'b1, 1'b0, '0, 1'b0, 0);
      feed(N, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, '0, 1'b0, 0);
      check_val("csum_full", csum, 16'h7F80);
      cyc(1'b1, 1'b1, 16'h0001, 1'b0, 0);
      check_val("csum_clear", csum, 16'h0000);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
